// File: rtl/inst_encoder_pkg.sv
// Shared types for the instruction encoder: the instruction-class, ALU and
// branch function enums (same encoding as the decoder's), the RV32 opcode
// constants, the canonical NOP word and small field-mapping helpers.
package inst_encoder_pkg;

  typedef enum logic [3:0] {
    IT_OP    = 4'd0,
    IT_OPIMM = 4'd1,
    IT_LOAD  = 4'd2,
    IT_STORE = 4'd3,
    IT_BRANCH= 4'd4,
    IT_JAL   = 4'd5,
    IT_JALR  = 4'd6,
    IT_LUI   = 4'd7,
    IT_AUIPC = 4'd8,
    IT_MUL   = 4'd9,
    IT_DIV   = 4'd10,
    IT_NOP   = 4'd11
  } itype_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_func_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NEQ = 3'd1,
    BR_LT  = 3'd2,
    BR_GE  = 3'd3,
    BR_LTU = 3'd4,
    BR_GEU = 3'd5,
    BR_DBR = 3'd6
  } br_func_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_WORD = 32'h00000013;

  typedef struct packed {
    logic       ok;
    logic [2:0] f3;
    logic [6:0] f7;
  } alu_enc_t;

  typedef struct packed {
    logic       ok;
    logic [2:0] f3;
  } br_enc_t;

  // True when v is representable as a two's-complement number of 'bits' bits:
  // everything from the sign bit upward must be a copy of it.
  function automatic logic fits_signed(input logic signed [31:0] v, input int unsigned bits);
    logic signed [31:0] hi;
    hi = v >>> (bits - 1);
    return (hi == 32'sd0) || (hi == -32'sd1);
  endfunction

  function automatic alu_enc_t alu_enc(input alu_func_e f);
    alu_enc_t e;
    e = '{ok: 1'b1, f3: 3'b000, f7: 7'h00};
    case (f)
      ALU_ADD:  e.f3 = 3'b000;
      ALU_SUB:  begin e.f3 = 3'b000; e.f7 = 7'h20; end
      ALU_SLL:  e.f3 = 3'b001;
      ALU_SLT:  e.f3 = 3'b010;
      ALU_SLTU: e.f3 = 3'b011;
      ALU_XOR:  e.f3 = 3'b100;
      ALU_SRL:  e.f3 = 3'b101;
      ALU_SRA:  begin e.f3 = 3'b101; e.f7 = 7'h20; end
      ALU_OR:   e.f3 = 3'b110;
      ALU_AND:  e.f3 = 3'b111;
      default:  e.ok = 1'b0;
    endcase
    return e;
  endfunction

  function automatic br_enc_t br_enc(input br_func_e f);
    br_enc_t e;
    e = '{ok: 1'b1, f3: 3'b000};
    case (f)
      BR_EQ:   e.f3 = 3'b000;
      BR_NEQ:  e.f3 = 3'b001;
      BR_LT:   e.f3 = 3'b100;
      BR_GE:   e.f3 = 3'b101;
      BR_LTU:  e.f3 = 3'b110;
      BR_GEU:  e.f3 = 3'b111;
      default: e.ok = 1'b0;   // Dbr and unused codes have no encoding
    endcase
    return e;
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-bundle / machine-word bus of the instruction encoder.
//   Input side : in_valid/in_ready handshake plus decoded fields
//                (iType_in, aluFunc_in, brFunc_in, funct3_in, imm_in,
//                rs1_in, rs2_in, rd_in).
//   Output side: out_valid/out_ready handshake plus instruction_out,
//                addr_out, illegal_out, err_count_out.
//   master = producer of fields / consumer of words; slave = the encoder.
interface inst_encoder_if #(
  parameter int DEPTH = 1024,
  parameter int ERR_W = 8
);
  import inst_encoder_pkg::*;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                   in_valid;
  logic                   in_ready;
  itype_e                 iType_in;
  alu_func_e              aluFunc_in;
  br_func_e               brFunc_in;
  logic        [2:0]      funct3_in;
  logic signed [31:0]     imm_in;
  logic        [4:0]      rs1_in;
  logic        [4:0]      rs2_in;
  logic        [4:0]      rd_in;
  logic                   out_valid;
  logic                   out_ready;
  logic        [31:0]     instruction_out;
  logic        [AW-1:0]   addr_out;
  logic                   illegal_out;
  logic        [ERR_W-1:0] err_count_out;

  modport master (
    output in_valid, iType_in, aluFunc_in, brFunc_in, funct3_in, imm_in,
           rs1_in, rs2_in, rd_in, out_ready,
    input  in_ready, out_valid, instruction_out, addr_out, illegal_out,
           err_count_out
  );

  modport slave (
    input  in_valid, iType_in, aluFunc_in, brFunc_in, funct3_in, imm_in,
           rs1_in, rs2_in, rd_in, out_ready,
    output in_ready, out_valid, instruction_out, addr_out, illegal_out,
           err_count_out
  );
endinterface

// File: rtl/inst_encoder_pack.sv
// inst_pack: purely combinational packing of decoded fields into an RV32IM
// machine word, with a legality flag.
//   Inputs : itype_i, alu_i, br_i, funct3_i, imm_i (byte-offset form),
//            rs1_i, rs2_i, rd_i
//   Outputs: word_o (meaningful only when legal_o), legal_o
module inst_pack
  import inst_encoder_pkg::*;
(
  input  itype_e             itype_i,
  input  alu_func_e          alu_i,
  input  br_func_e           br_i,
  input  logic        [2:0]  funct3_i,
  input  logic signed [31:0] imm_i,
  input  logic        [4:0]  rs1_i,
  input  logic        [4:0]  rs2_i,
  input  logic        [4:0]  rd_i,
  output logic        [31:0] word_o,
  output logic               legal_o
);

  alu_enc_t ae;
  br_enc_t  be;
  logic     is_shift;

  assign ae       = alu_enc(alu_i);
  assign be       = br_enc(br_i);
  assign is_shift = ae.ok && ((ae.f3 == 3'b001) || (ae.f3 == 3'b101));

  always_comb begin
    word_o  = NOP_WORD;
    legal_o = 1'b0;
    case (itype_i)
      IT_OP: begin
        legal_o = ae.ok;
        word_o  = {ae.f7, rs2_i, rs1_i, ae.f3, rd_i, OPC_OP};
      end
      IT_OPIMM: begin
        if (is_shift) begin
          // Shift amount is an unsigned 0..31 field; funct7 sits above it.
          legal_o = (imm_i[31:5] == '0);
          word_o  = {ae.f7, imm_i[4:0], rs1_i, ae.f3, rd_i, OPC_OPIMM};
        end else begin
          legal_o = ae.ok && (alu_i != ALU_SUB) && fits_signed(imm_i, 12);
          word_o  = {imm_i[11:0], rs1_i, ae.f3, rd_i, OPC_OPIMM};
        end
      end
      IT_LOAD: begin
        legal_o = funct3_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        word_o  = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_LOAD};
      end
      IT_STORE: begin
        legal_o = (funct3_i < 3'd3);
        word_o  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_STORE};
      end
      IT_BRANCH: begin
        legal_o = be.ok && !imm_i[0] && fits_signed(imm_i, 13);
        word_o  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, be.f3,
                   imm_i[4:1], imm_i[11], OPC_BRANCH};
      end
      IT_JAL: begin
        legal_o = !imm_i[0] && fits_signed(imm_i, 21);
        word_o  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
      end
      IT_JALR: begin
        legal_o = fits_signed(imm_i, 12);
        word_o  = {imm_i[11:0], rs1_i, 3'b000, rd_i, OPC_JALR};
      end
      IT_LUI: begin
        legal_o = (imm_i[11:0] == 12'h000);
        word_o  = {imm_i[31:12], rd_i, OPC_LUI};
      end
      IT_AUIPC: begin
        legal_o = (imm_i[11:0] == 12'h000);
        word_o  = {imm_i[31:12], rd_i, OPC_AUIPC};
      end
      IT_MUL: begin
        legal_o = !funct3_i[2];
        word_o  = {7'b0000001, rs2_i, rs1_i, funct3_i, rd_i, OPC_OP};
      end
      IT_DIV: begin
        legal_o = funct3_i[2];
        word_o  = {7'b0000001, rs2_i, rs1_i, funct3_i, rd_i, OPC_OP};
      end
      IT_NOP: begin
        legal_o = 1'b1;
        word_o  = NOP_WORD;
      end
      default: begin
        legal_o = 1'b0;
        word_o  = NOP_WORD;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: accepts decoded instruction fields, emits the RV32IM word
// through one backpressured output register, with a wrapping write address
// for instruction-memory loading and a saturating illegal-bundle counter.
//   clk_in   : clock
//   rst_in   : synchronous active-high reset
//   flush_in : drop the held word, reload the address counter with BASE_ADDR
//   bus      : inst_encoder_if slave (field handshake in, word handshake out)
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int BASE_ADDR = 0,
  parameter int ERR_W     = 8
)(
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          flush_in,
  inst_encoder_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  logic [31:0]      pk_word;
  logic             pk_legal;
  logic             accept;
  logic             xfer;

  logic             vld_p1_q,   vld_p1_d;
  logic [31:0]      instr_p1_q, instr_p1_d;
  logic             ill_p1_q,   ill_p1_d;
  logic [AW-1:0]    addr_q,     addr_d;
  logic [ERR_W-1:0] err_q,      err_d;

  inst_pack u_pack (
    .itype_i  (bus.iType_in),
    .alu_i    (bus.aluFunc_in),
    .br_i     (bus.brFunc_in),
    .funct3_i (bus.funct3_in),
    .imm_i    (bus.imm_in),
    .rs1_i    (bus.rs1_in),
    .rs2_i    (bus.rs2_in),
    .rd_i     (bus.rd_in),
    .word_o   (pk_word),
    .legal_o  (pk_legal)
  );

  assign bus.in_ready = !vld_p1_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign xfer         = vld_p1_q && bus.out_ready;

  // ---- stage p0 -> p1: output register, address and error accounting ----
  always_comb begin
    vld_p1_d   = vld_p1_q;
    instr_p1_d = instr_p1_q;
    ill_p1_d   = ill_p1_q;
    addr_d     = addr_q;
    err_d      = err_q;
    if (flush_in) begin
      // Flush beats a same-cycle accept: the bundle is dropped, no count.
      vld_p1_d = 1'b0;
      ill_p1_d = 1'b0;
      addr_d   = AW'(BASE_ADDR);
    end else begin
      if (xfer) begin
        addr_d = wrap_inc(addr_q);
      end
      if (accept) begin
        vld_p1_d   = 1'b1;
        instr_p1_d = pk_legal ? pk_word : NOP_WORD;
        ill_p1_d   = !pk_legal;
        if (!pk_legal) begin
          err_d = sat_inc(err_q);
        end
      end else if (xfer) begin
        vld_p1_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_p1_q   <= 1'b0;
      instr_p1_q <= '0;
      ill_p1_q   <= 1'b0;
      addr_q     <= AW'(BASE_ADDR);
      err_q      <= '0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      instr_p1_q <= instr_p1_d;
      ill_p1_q   <= ill_p1_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
    end
  end

  assign bus.out_valid       = vld_p1_q;
  assign bus.instruction_out = instr_p1_q;
  assign bus.addr_out        = addr_q;
  assign bus.illegal_out     = ill_p1_q;
  assign bus.err_count_out   = err_q;

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the instruction decoder. Accepts decoded instruction fields (iType/aluFunc/brFunc enums, immediate, register indices) over a valid/ready handshake.
- Produces the 32-bit RV32IM machine word, together with a sequential write address for loading instruction memory.
- Used by the program loader and the testbench to build instruction ROM/BRAM images, and to round-trip-check the decoder.
- Contains one registered output stage with backpressure, an address counter and error accounting.

Parameters:
- DEPTH, 1024, number of instruction-memory words; address counter wraps at DEPTH.
- BASE_ADDR, 0, word address loaded into the counter on reset and on flush.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- flush_in  input  1  drops the held output and reloads the address counter with BASE_ADDR
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept a bundle this cycle
- iType_in  input  4  instruction class enum from the shared types header
- aluFunc_in  input  4  ALU function enum (OP/OPIMM)
- brFunc_in  input  3  branch function enum (BRANCH)
- funct3_in  input  3  explicit funct3 for LOAD/STORE/MUL/DIV; ignored otherwise
- imm_in  input  32  signed immediate, in byte-offset form as the decoder emits it
- rs1_in  input  5  source register 1
- rs2_in  input  5  source register 2
- rd_in  input  5  destination register
- out_valid  output  1  instruction_out/addr_out valid; doubles as memory write enable
- out_ready  input  1  consumer accepts the word
- instruction_out  output  32  encoded instruction
- addr_out  output  $clog2(DEPTH)  word address for instruction_out
- illegal_out  output  1  held word was substituted because the bundle was illegal
- err_count_out  output  ERR_W  saturating count of illegal bundles

Behaviour:
- Reset (rst_in synchronous, active-high) sets these values:
  - out_valid=0, instruction_out=0, illegal_out=0, err_count_out=0;
  - address counter=BASE_ADDR, so addr_out=BASE_ADDR.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - An input is accepted when in_valid && in_ready.
  - Latency is 1 cycle: the encoded word is registered and out_valid rises on the next edge.
  - Full throughput when out_ready=1.
  - While out_valid && !out_ready, all outputs hold stable and in_ready=0.
- Address counter and addr_out:
  - The counter increments on each output transfer (out_valid && out_ready).
  - It wraps from DEPTH-1 to 0.
  - addr_out always shows the counter value for the held word.
- Simultaneous transfer and accept: out_valid stays 1 and the new word loads. The counter advances once.
- flush_in:
  - Same cycle as an accept: flush wins, and the bundle is dropped.
  - Clears out_valid and illegal_out and reloads the counter.
  - err_count_out is kept.
- Encoding by iType:
  - OP uses opcode 0110011.
    - funct3/funct7 by aluFunc: Add 000/00, Sub 000/20, Sll 001/00, Slt 010/00, Sltu 011/00, Xor 100/00, Srl 101/00, Sra 101/20, Or 110/00, And 111/00.
  - OPIMM uses opcode 0010011.
    - Same funct3 mapping as OP; Sub is illegal.
    - Shifts put imm[4:0] in [24:20] and funct7 (00, or 20 for Sra) in [31:25]; shift imm must be 0..31.
    - Otherwise imm must fit signed 12 bits.
  - LOAD uses opcode 0000011; funct3 must be one of {0,1,2,4,5}.
  - STORE uses opcode 0100011, S-format; funct3 must be one of {0,1,2}.
  - BRANCH uses opcode 1100011, B-format.
    - funct3 by brFunc: Eq 000, Neq 001, Lt 100, Ge 101, Ltu 110, Geu 111.
    - Dbr is illegal.
    - imm must be even and fit signed 13 bits.
  - JAL uses opcode 1101111, J-format; imm must be even and fit signed 21 bits.
  - JALR uses opcode 1100111 with funct3 000; imm must fit signed 12 bits.
  - LUI uses opcode 0110111 and AUIPC uses opcode 0010111, both U-format; imm[11:0] must be 0.
  - MUL/DIV use opcode 0110011 with funct7 0000001.
    - MUL requires funct3<4; DIV requires funct3>=4.
  - NOP encodes as 0x00000013 and is not an error.
  - Any other iType is illegal.
- Fields not used by a format are not encoded (e.g. rs2 for I-type).
- Illegal bundle handling:
  - The bundle is accepted normally.
  - instruction_out=0x00000013 and illegal_out=1 for that word.
  - err_count_out increments on accept and saturates at all-ones.

Decomposition:
- Shared types header:
  - iType/aluFunc/brFunc enums, reused unchanged;
  - add opcode localparams (OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC);
  - add NOP_WORD=32'h00000013.
- Sub-module inst_pack: purely combinational fields -> {word, legal}.
- inst_encoder holds the handshake, output register, address counter and error counter.

Test Plan:
- OP Add rs1=1 rs2=2 rd=3, out_ready=1 -> instruction_out=0x002081B3 one cycle later, addr_out=BASE_ADDR, illegal_out=0.
- OPIMM Add rs1=0 rd=1 imm=-1 -> 0xFFF00093; then BRANCH Eq rs1=1 rs2=2 imm=-4 -> 0xFE208EE3 on the next cycle, addr_out=BASE_ADDR+1.
- LUI rd=5 imm=0x12345000 -> 0x123452B7; LUI imm=0x12345001 -> 0x00000013, illegal_out=1, err_count_out=1.
- Backpressure:
  - Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable.
  - Release -> words emitted in order, no loss or duplication.
- Wrap with DEPTH=4, BASE_ADDR=2: 4 transfers -> addr_out sequence 2,3,0,1.
- Assert flush_in while out_valid=1 and in_valid=1 -> next cycle out_valid=0 and addr_out=BASE_ADDR, bundle dropped, err_count_out unchanged.
- Reset mid-stream with out_valid=1 -> every output returns to its reset value.
